cplx_reg_bank_p: RTL

Parametrised complex-word register bank: DEPTH registers, each holding a real half-word (upper) and an imaginary half-word (lower) of HW bits, with two registered read ports. It keeps the half-word write enables, swap mode and small-integer constant override of the existing bank, and adds same-cycle read bypass, a multi-cycle bank-fill engine, and per-port output-valid strobes. It sits between the datapath load/store logic and the complex ALU operand inputs.

---
 rtl/cplx_reg_bank_p_if.sv | 43 ++++
 rtl/cplx_reg_bank_p.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cplx_reg_bank_p_if.sv
// Bus bundle for cplx_reg_bank_p.
// Carries the write port, both read ports, the fill-engine controls and the
// status strobes. The master side (load/store logic or a bench) drives the
// requests. The slave side (the bank) drives outA/outB, vldA/vldB, busy,
// clr_done and wr_drop.
interface cplx_reg_bank_p_if #(
  parameter int HW = 32,
  parameter int AW = 4
);
  localparam int W = 2 * HW;

  logic          regwe;
  logic [W-1:0]  inA;
  logic [AW-1:0] selwreg;
  logic [1:0]    endreg;
  logic [AW-1:0] seloutA;
  logic [AW-1:0] seloutB;
  logic          cnstA;
  logic          cnstB;
  logic          enrregA;
  logic          enrregB;
  logic [W-1:0]  outA;
  logic [W-1:0]  outB;
  logic          vldA;
  logic          vldB;
  logic          clr_start;
  logic [W-1:0]  clr_val;
  logic          busy;
  logic          clr_done;
  logic          wr_drop;

  modport master (
    output regwe, inA, selwreg, endreg, seloutA, seloutB,
           cnstA, cnstB, enrregA, enrregB, clr_start, clr_val,
    input  outA, outB, vldA, vldB, busy, clr_done, wr_drop
  );

  modport slave (
    input  regwe, inA, selwreg, endreg, seloutA, seloutB,
           cnstA, cnstB, enrregA, enrregB, clr_start, clr_val,
    output outA, outB, vldA, vldB, busy, clr_done, wr_drop
  );
endinterface

// File: rtl/cplx_reg_bank_p.sv
// Complex-word register bank.
// DEPTH = 2**AW words. Each word is {real, imag} and each half is HW bits.
// The bank has one write port with half-word enables and a swap mode, plus
// two registered read ports. Each read port can load either a bank word or a
// small signed constant. The bank also has a fill engine that writes one
// value into every register, one index per clock.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low; clears bank, ports, strobes and FSM
//   bus   : cplx_reg_bank_p_if.slave (write/read/fill requests, outputs)
module cplx_reg_bank_p #(
  parameter int HW = 32,
  parameter int AW = 4
) (
  input  logic              clock,
  input  logic              reset,
  cplx_reg_bank_p_if.slave  bus
);
  localparam int W     = 2 * HW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [W-1:0]  fill_val;
  logic [W-1:0]  regbank  [DEPTH];
  logic [W-1:0]  bank_nxt [DEPTH];
  logic          wr_go;
  logic          fill_go;
  logic [W-1:0]  wr_word;

  // Merge a write into the old word according to the half-word mode.
  function automatic logic [W-1:0] merge_word(input logic [W-1:0] old,
                                              input logic [W-1:0] din,
                                              input logic [1:0]   mode);
    case (mode)
      2'b00:   return din;
      2'b01:   return {din[W-1:HW], old[HW-1:0]};
      2'b10:   return {old[W-1:HW], din[HW-1:0]};
      default: return {din[HW-1:0], din[W-1:HW]};
    endcase
  endfunction

  // Build the small-integer constant.
  // real = {sel[1], sel[3]} and imag = {sel[0], sel[2]}, read as 2-bit
  // signed values and sign-extended to HW bits.
  function automatic logic [W-1:0] cnst_word(input logic [3:0] sel);
    logic signed [1:0]    re2;
    logic signed [1:0]    im2;
    logic signed [HW-1:0] re;
    logic signed [HW-1:0] im;
    re2 = {sel[1], sel[3]};
    im2 = {sel[0], sel[2]};
    re  = {{(HW-2){re2[1]}}, re2};
    im  = {{(HW-2){im2[1]}}, im2};
    return {re, im};
  endfunction

  // Writes are only honoured in IDLE. While busy, the fill engine owns the
  // bank.
  assign wr_go   = bus.regwe && (state == IDLE);
  assign fill_go = (state == FILL);
  assign wr_word = merge_word(regbank[bus.selwreg], bus.inA, bus.endreg);

  // Post-edge bank image. Read ports sample this image, which gives
  // same-edge bypass of writes and fill writes, including partial and swap
  // merges.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      bank_nxt[i] = regbank[i];
      if (fill_go && (cnt == AW'(i)))
        bank_nxt[i] = fill_val;
      else if (wr_go && (bus.selwreg == AW'(i)))
        bank_nxt[i] = wr_word;
    end
  end

  // ---- register stage: bank, fill FSM, read ports ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      fill_val     <= '0;
      for (int i = 0; i < DEPTH; i++) regbank[i] <= '0;
      bus.outA     <= '0;
      bus.outB     <= '0;
      bus.vldA     <= 1'b0;
      bus.vldB     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.clr_done <= 1'b0;
      bus.wr_drop  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regbank[i] <= bank_nxt[i];

      bus.clr_done <= 1'b0;
      bus.wr_drop  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            fill_val <= bus.clr_val;
            cnt      <= '0;
            state    <= FILL;
            bus.busy <= 1'b1;
          end
        end
        FILL: begin
          cnt <= cnt + 1'b1;
          if (bus.regwe) bus.wr_drop <= 1'b1;
          if (cnt == '1) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A constant load takes priority over a bank read.
      if (bus.cnstA) begin
        bus.outA <= cnst_word(bus.seloutA[3:0]);
        bus.vldA <= 1'b1;
      end else if (bus.enrregA) begin
        bus.outA <= bank_nxt[bus.seloutA];
        bus.vldA <= 1'b1;
      end else begin
        bus.vldA <= 1'b0;
      end

      if (bus.cnstB) begin
        bus.outB <= cnst_word(bus.seloutB[3:0]);
        bus.vldB <= 1'b1;
      end else if (bus.enrregB) begin
        bus.outB <= bank_nxt[bus.seloutB];
        bus.vldB <= 1'b1;
      end else begin
        bus.vldB <= 1'b0;
      end
    end
  end
endmodule
